// File: rtl/bus_timer_pkg.sv
// Shared peripheral definitions for the bus timer: register offsets within
// the 16-byte register window and TCON bit positions.
package bus_timer_pkg;

  // Byte offsets from the timer base address (low nibble of the bus address)
  localparam logic [3:0] TIMER_TH_OFS      = 4'h0;
  localparam logic [3:0] TIMER_TL_OFS      = 4'h4;
  localparam logic [3:0] TIMER_TCON_OFS    = 4'h8;
  localparam logic [3:0] TIMER_SYSTICK_OFS = 4'hC;

  // TCON bit positions
  localparam int TCON_EN = 0;  // counting enable
  localparam int TCON_IE = 1;  // interrupt enable
  localparam int TCON_ST = 2;  // sticky overflow status

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator for the bus timer: divides clk by PRESCALE while enabled.
// tick is combinational from the count so that, with PRESCALE=1, the first
// tick lands on the first edge after the enable is written.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count 0..PRESCALE-1 while enabled; hold at 0 while disabled
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped interval timer with overflow interrupt and a free-running
// SYSTICK cycle counter. BASE_ADDR must be 16-byte aligned.
// Build option: define BUS_TIMER_SYSTICK_EN to implement SYSTICK at 0x0C;
// otherwise no counter flops exist and 0x0C reads as 0.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_addr,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic        i_rd_en,
  output logic [31:0] o_rd_data,
  output logic        o_irq
);

  logic [31:0] th;
  logic [31:0] tl;
  logic        en;
  logic        ie;
  logic        st;
  logic [31:0] systick;
  logic        tick;

  // The window is matched on the upper 28 bits; the low nibble selects a word
  logic win_hit;
  logic wr_th, wr_tl, wr_tcon;
  logic overflow;

  assign win_hit  = (i_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_th    = i_wr_en && win_hit && (i_addr[3:0] == TIMER_TH_OFS);
  assign wr_tl    = i_wr_en && win_hit && (i_addr[3:0] == TIMER_TL_OFS);
  assign wr_tcon  = i_wr_en && win_hit && (i_addr[3:0] == TIMER_TCON_OFS);
  // A TL write in the same cycle as a tick discards that tick entirely
  assign overflow = tick && !wr_tl && (tl == TL_MAX);

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick)
  );

  // Reload register; an overflow in the same cycle still reloads the old TH
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      th <= '0;
    else if (wr_th) th <= i_wr_data;
  end

  // Count register: software write wins over a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         tl <= '0;
    else if (wr_tl)    tl <= i_wr_data;
    else if (overflow) tl <= th;
    else if (tick)     tl <= tl + 32'd1;
  end

  // Control/status; hardware overflow beats a software clear of ST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en <= 1'b0;
      ie <= 1'b0;
      st <= 1'b0;
    end else begin
      if (wr_tcon) begin
        en <= i_wr_data[TCON_EN];
        ie <= i_wr_data[TCON_IE];
      end
      if (overflow)                           st <= 1'b1;
      else if (wr_tcon && !i_wr_data[TCON_ST]) st <= 1'b0;
    end
  end

  // Registered interrupt request: follows ST & IE one edge later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_irq <= 1'b0;
    else       o_irq <= st && ie;
  end

`ifdef BUS_TIMER_SYSTICK_EN
  // Free-running cycle counter, wraps naturally, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) systick <= '0;
    else       systick <= systick + 32'd1;
  end
`else
  assign systick = '0;
`endif

  // Combinational read mux; zero when not reading or outside the window
  // NOTE: o_rd_data gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_rd_data = '0;
    if (i_rd_en && win_hit) begin
      case (i_addr[3:0])
        TIMER_TH_OFS:      o_rd_data = th;
        TIMER_TL_OFS:      o_rd_data = tl;
        TIMER_TCON_OFS:    o_rd_data = {29'd0, st, ie, en};
        TIMER_SYSTICK_OFS: o_rd_data = systick;
        default:           o_rd_data = '0;
      endcase
    end
  end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped interval timer with interrupt and read-only cycle counter, the CPU-facing counterpart of the free-running system clock counter. Sits on the peripheral bus beside data memory. The pipeline CPU programs a reload value, enables counting, takes an interrupt on overflow, and reads elapsed cycles for software timing.

## Interface
- BASE_ADDR, 32'h4000_0000, byte address of the register window
- PRESCALE, 1, clk cycles per timer tick (≥1)
- reset  in  1  asynchronous, active-high; clears all state
- clk  in  1  system clock, rising edge
- i_addr  in  32  byte address of bus access
- i_wr_en  in  1  write strobe, sampled at rising clk
- i_wr_data  in  32  write data
- i_rd_en  in  1  read strobe
- o_rd_data  out  32  read data, combinational
- o_irq  out  1  registered interrupt request

## Operation
- Register map, offsets from BASE_ADDR:
  - 0x00 TH, R/W
  - 0x04 TL, R/W
  - 0x08 TCON, R/W, bits [2:0]
  - 0x0C SYSTICK, read-only; writes ignored
- TCON bits:
  - bit0 EN: counting enable
  - bit1 IE: interrupt enable
  - bit2 ST: overflow status, sticky
- Addresses outside the four words: reads return 0; writes have no effect.
- Tick generation:
  - Prescaler counts 0..PRESCALE-1 while EN=1.
  - A tick is asserted when the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - The prescaler is held at 0 while EN=0.
- On a tick:
  - If TL == 32'hFFFF_FFFF, TL ← TH and ST ← 1.
  - Otherwise TL ← TL+1.
- o_irq ← ST & IE, registered.
- ST clears only on a software write to TCON with bit2=0. Writing 1 to bit2 has no effect.
- SYSTICK increments every clk from reset and wraps 32'hFFFF_FFFF → 0. It is never cleared except by reset.
- Simultaneous events:
  - TL write and tick in the same cycle: the write wins and the increment is lost.
  - TCON write clearing ST in the same cycle as an overflow: ST=1, because hardware set wins.
  - TH write in the same cycle as an overflow reload: TL takes the old TH.
- Reset mid-count: TL, TH, TCON, the prescaler, SYSTICK and o_irq all return to 0 immediately, with no clock needed.

## Timing
- Reset values: o_irq=0, o_rd_data reflects registers, which are all 0.
- Writes take effect at the rising edge where i_wr_en=1. A read in the following cycle returns the new value.
- o_rd_data is combinational from i_addr/i_rd_en. It is 0 when i_rd_en=0.
- Interrupt latency: an overflow tick at edge N sets ST at edge N. o_irq rises at edge N+1.
- With PRESCALE=1 and EN=1, TL advances every cycle. The first increment occurs at the first edge after EN is written.
- Period from reload to overflow: (2^32 − TH) ticks.

## Configuration
- BUS_TIMER_SYSTICK_EN
  - Defined: SYSTICK counter is implemented and readable at 0x0C.
  - Undefined: no counter flops; reads of 0x0C return 0.

## Structure
- The shared peripheral package holds:
  - register offset constants (TIMER_TH_OFS, TIMER_TL_OFS, TIMER_TCON_OFS, TIMER_SYSTICK_OFS)
  - TCON bit index constants (TCON_EN, TCON_IE, TCON_ST)
- One sub-module: timer_prescaler, which outputs a one-cycle tick pulse and has parameter PRESCALE.
- Register file, TL/TH logic and the read mux remain in bus_timer.

## Test plan
- Reset, then read all four offsets: each returns 0. o_irq=0.
- PRESCALE=1, TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3:
  - TL reads FFFF_FFFF one cycle later.
  - TL reloads to FFFF_FFF0 and ST=1 on the next tick.
  - o_irq=1 one cycle after that.
- With ST=1, write TCON=3:
  - ST clears and o_irq falls the following cycle.
  - Repeat with the write landing on an overflow edge: ST stays 1.
- PRESCALE=4, TL=0, EN=1 for 20 cycles: TL=5. Clear EN, wait 10 cycles: TL stays 5.
- Assert reset mid-count with TL=32'h1234: all registers read 0 and o_irq=0 before the next clk edge.
- With BUS_TIMER_SYSTICK_EN, read 0x0C at cycle 100 after reset: value 100. Without the macro: value 0. A write to 0x0C is ignored in both cases.
